// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: byte, valid/ack, busy and error flags.
// The receiver drives through the master modport; the consumer uses slave.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_ack;
  logic       busy;
  logic       framing_err;
  logic       overrun_err;
  logic       parity_err;

  modport master (
    output data_out, data_valid, busy, framing_err, overrun_err, parity_err,
    input  rx_ack
  );

  modport slave (
    input  data_out, data_valid, busy, framing_err, overrun_err, parity_err,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 deserialiser with valid/ack holding register.
// Define UART_RX_PARITY_EN to insert a parity bit (even/odd chosen by PARITY_ODD).
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       rx_pin,
  uart_rx_if.master  bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_rx: OVERSAMPLE must be even and >= 4, PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;
  logic            frame_ok;

  logic [7:0]      data_q;
  logic            valid_q;
  logic            busy_q;
  logic            framing_q;
  logic            overrun_q;
  logic            parity_q;

  // NOTE: synchroniser flops reset to the idle line level (1) so reset release
  // never looks like a start-bit falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
  assign frame_ok = rx_s && !parity_bad;
`else
  assign frame_ok = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_prev   <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      framing_q <= 1'b0;
      parity_q  <= 1'b0;

      // NOTE: the commit below is written after the ack clear, so when both
      // happen on one edge the later non-blocking assignment (new byte) wins.
      if (bus.rx_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      if (sample_tick) begin
        rx_prev <= rx_s;
        case (state)
          IDLE: begin
            if (!rx_s && rx_prev) begin
              state  <= START;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end

          START: begin
            if (cnt == HALF_LAST) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == BIT_LAST) begin
              shift[bit_idx] <= rx_s;
              cnt            <= '0;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == BIT_LAST) begin
              parity_bad <= rx_s != ((^shift) ^ 1'(PARITY_ODD));
              cnt        <= '0;
              state      <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            if (cnt == BIT_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              busy_q    <= 1'b0;
              framing_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
              parity_q  <= parity_bad;
`endif
              if (frame_ok) begin
                data_q  <= shift;
                valid_q <= 1'b1;
                if (valid_q && !bus.rx_ack) overrun_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.busy        = busy_q;
  assign bus.framing_err = framing_q;
  assign bus.overrun_err = overrun_q;
  assign bus.parity_err  = parity_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// compared against a frame-level behavioural model of the receiver.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int PAR_ODD  = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic clk         = 1'b0;
  logic rst_n       = 1'b0;
  logic sample_tick = 1'b0;
  logic rx_pin      = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OS), .PARITY_ODD(PAR_ODD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .rx_pin      (rx_pin),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int d;
    d = 0;
    forever begin
      @(posedge clk);
      #1;
      d = (d + 1) % TICK_DIV;
      sample_tick = (d == 0);
    end
  end

  // Output monitors, sampled on the falling edge
  int   framing_cnt = 0;
  int   parity_cnt  = 0;
  int   busy_cyc    = 0;
  int   rise_cyc    = -1;
  logic prev_valid  = 1'b0;
  always @(negedge clk) begin
    if (bus.framing_err) framing_cnt++;
    if (bus.parity_err)  parity_cnt++;
    if (bus.busy)        busy_cyc++;
    if (bus.data_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.data_valid;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: state of the holding register after whole frames
  logic [7:0] exp_data    = 8'h00;
  logic       exp_valid   = 1'b0;
  logic       exp_overrun = 1'b0;
  int         exp_framing = 0;
  int         exp_parity  = 0;
  int         start_cyc   = 0;

  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
    logic par_ok;
    par_ok = !(PARITY_ON && flip);
    if (!stop_bit) exp_framing++;
    if (!par_ok) exp_parity++;
    if (stop_bit && par_ok) begin
      if (exp_valid) exp_overrun = 1'b1;
      exp_data  = b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
    #2;
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PARITY_ON) drive_bit((^b) ^ PAR_ODD[0] ^ flip);
    drive_bit(stop_bit);
    rx_pin = 1'b1;
    wait_ticks(2 * OS);
    model_frame(b, stop_bit, flip);
  endtask

  task automatic do_ack();
    @(posedge clk);
    #1 bus.rx_ack = 1'b1;
    @(posedge clk);
    #1 bus.rx_ack = 1'b0;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 32'(bus.data_valid), 32'(exp_valid));
    if (exp_valid) check({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
    check({tag, "_overrun"}, 32'(bus.overrun_err), 32'(exp_overrun));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_framing_pulses"}, 32'(framing_cnt), 32'(exp_framing));
    check({tag, "_parity_pulses"}, 32'(parity_cnt), 32'(exp_parity));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int b0;
    logic [7:0] rb;
    logic       rs;
    logic       rf;

    bus.rx_ack = 1'b0;
    #1;
    check("rst_data_out",    32'(bus.data_out),    32'h00);
    check("rst_data_valid",  32'(bus.data_valid),  32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_framing_err", 32'(bus.framing_err), 32'd0);
    check("rst_overrun_err", 32'(bus.overrun_err), 32'd0);
    check("rst_parity_err",  32'(bus.parity_err),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // Single clean frame and its latency
    send_frame(8'hA5, 1'b1, 1'b0);
    lat = rise_cyc - start_cyc;
    check("latency_611pm3", 32'(lat >= 608 && lat <= 614), 32'd1);
    check_state("a5");

    // Overrun, then ack clears valid and overrun on the next edge
    do_ack();
    check_state("ack_a5");
    send_frame(8'h3C, 1'b1, 1'b0);
    check_state("b3c");
    send_frame(8'hC3, 1'b1, 1'b0);
    check_state("overrun_c3");
    do_ack();
    check_state("ack_overrun");

    // Framing error leaves the held byte untouched
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    check_state("framing_55");

    // Line held low for three frame times decodes as one framing error only
    rx_pin = 1'b0;
    exp_framing++;
    wait_ticks(3 * 10 * OS);
    rx_pin = 1'b1;
    wait_ticks(2 * OS);
    check_state("held_low");
    do_ack();
    send_frame(8'h6E, 1'b1, 1'b0);
    check_state("after_break");

    // Five-tick glitch: start rejected at mid start bit, busy for eight ticks
    b0 = busy_cyc;
    rx_pin = 1'b0;
    wait_ticks(5);
    rx_pin = 1'b1;
    wait_ticks(2 * OS);
    check("glitch_busy_clks", 32'(busy_cyc - b0), 32'(OS / 2 * TICK_DIV));
    check_state("glitch");

    // Random frames with occasional bad stop bits, bad parity and acks
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      rf = ($urandom_range(0, 4) == 0);
      send_frame(rb, rs, rf);
      if ($urandom_range(0, 1) == 1) do_ack();
      check_state($sformatf("rand%0d", n));
    end

    // Reset in the middle of data bit 4 of 0xFF
    send_frame(8'h3A, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_ticks(OS / 2);
    check("busy_mid_frame", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    rx_pin = 1'b1;
    #1;
    check("midrst_data_out",   32'(bus.data_out),    32'h00);
    check("midrst_data_valid", 32'(bus.data_valid),  32'd0);
    check("midrst_busy",       32'(bus.busy),        32'd0);
    check("midrst_overrun",    32'(bus.overrun_err), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h81, 1'b1, 1'b0);
    check_state("post_rst_81");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 with parity bit 1 commits, with parity bit 0 is rejected
    do_ack();
    send_frame(8'h07, 1'b1, 1'b0);
    check_state("par_good_07");
    do_ack();
    send_frame(8'h07, 1'b1, 1'b1);
    check_state("par_bad_07");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
